// File: rtl/int_ctrl_if.sv
// int_ctrl_if: register port, interrupt lines and request/ack handshake of int_ctrl.
interface int_ctrl_if #(parameter int NUM_IRQ = 6, parameter int NUM_TIMERS = 2);
  logic [NUM_IRQ-1:0]    irq_i;
  logic                  we_i;
  logic [4:0]            waddr_i;
  logic [31:0]           wdata_i;
  logic [4:0]            raddr_i;
  logic [31:0]           rdata_o;
  logic                  irq_req_o;
  logic [4:0]            irq_id_o;
  logic                  ack_i;
  logic [NUM_TIMERS-1:0] timer_int_o;
  modport master (
    output irq_i, we_i, waddr_i, wdata_i, raddr_i, ack_i,
    input  rdata_o, irq_req_o, irq_id_o, timer_int_o
  );
  modport slave (
    input  irq_i, we_i, waddr_i, wdata_i, raddr_i, ack_i,
    output rdata_o, irq_req_o, irq_id_o, timer_int_o
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt/timer controller with fixed-priority request handshake.
// Define INTC_SYNC_EN to insert a two-flop synchroniser on irq_i.
module int_ctrl #(
  parameter int NUM_IRQ    = 6,
  parameter int NUM_TIMERS = 2,
  parameter int CNT_W      = 32
) (
  input logic clk,
  input logic rst,
  int_ctrl_if.slave bus
);
  localparam int NUM_SRC = NUM_IRQ + NUM_TIMERS;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state;
  logic [NUM_SRC-1:0] mask, pend, pend_nx, elig, clr, set, clrable, id_oh;
  logic [NUM_IRQ-1:0] mode, irq_q, prev_q, in_d;
  logic [NUM_TIMERS-1:0] ten, match, cmp_wr, cnt_wr;
  logic [CNT_W-1:0] cnt [NUM_TIMERS];
  logic [CNT_W-1:0] cmp [NUM_TIMERS];
  logic ie, req, any, eoi;
  logic [4:0] id, win;
  logic [31:0] rd;
`ifdef INTC_SYNC_EN
  logic [NUM_IRQ-1:0] s1, s2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.irq_i;
      s2 <= s1;
    end
  assign in_d = s2;
`else
  assign in_d = bus.irq_i;
`endif
  assign clrable = {{NUM_TIMERS{1'b1}}, mode};
  assign id_oh = NUM_SRC'(1) << id;
  assign eoi = bus.we_i && bus.waddr_i == 5'd4;
  // level sources mirror irq_q; edge and timer sources latch until cleared, set beats clear
  always_comb begin
    clr = (bus.we_i && bus.waddr_i == 5'd2) ? bus.wdata_i[NUM_SRC-1:0] : '0;
    clr = (state == REQ && bus.ack_i) ? clr | id_oh : clr;
    for (int k = 0; k < NUM_TIMERS; k++) begin
      match[k] = ten[k] && cnt[k] == cmp[k];
      cnt_wr[k] = bus.we_i && bus.waddr_i == 5'(8 + 2 * k);
      cmp_wr[k] = bus.we_i && bus.waddr_i == 5'(9 + 2 * k);
    end
    set = {match, irq_q & ~prev_q};
    pend_nx = (clrable & (set | (pend & ~clr))) | (~clrable & {{NUM_TIMERS{1'b0}}, irq_q});
    pend_nx[NUM_SRC-1:NUM_IRQ] = pend_nx[NUM_SRC-1:NUM_IRQ] & ~cmp_wr;
  end
  always_comb begin
    elig = pend & mask & {NUM_SRC{ie}};
    any = |elig;
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      win = elig[i] ? 5'(i) : win;
  end
  always_comb begin
    rd = '0;
    rd = bus.raddr_i == 5'd0 ? 32'(mask) : rd;
    rd = bus.raddr_i == 5'd1 ? 32'(mode) : rd;
    rd = bus.raddr_i == 5'd2 ? 32'(pend) : rd;
    rd = bus.raddr_i == 5'd3 ? 32'({ten, ie}) : rd;
    for (int k = 0; k < NUM_TIMERS; k++) begin
      rd = bus.raddr_i == 5'(8 + 2 * k) ? 32'(cnt[k]) : rd;
      rd = bus.raddr_i == 5'(9 + 2 * k) ? 32'(cmp[k]) : rd;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mask   <= '0;
      mode   <= '0;
      ie     <= 1'b0;
      ten    <= '0;
      pend   <= '0;
      irq_q  <= '0;
      prev_q <= '0;
      for (int k = 0; k < NUM_TIMERS; k++) begin
        cnt[k] <= '0;
        cmp[k] <= '0;
      end
    end else begin
      irq_q  <= in_d;
      prev_q <= irq_q;
      pend   <= pend_nx;
      if (bus.we_i && bus.waddr_i == 5'd0) mask <= bus.wdata_i[NUM_SRC-1:0];
      if (bus.we_i && bus.waddr_i == 5'd1) mode <= bus.wdata_i[NUM_IRQ-1:0];
      if (bus.we_i && bus.waddr_i == 5'd3) {ten, ie} <= bus.wdata_i[NUM_TIMERS:0];
      for (int k = 0; k < NUM_TIMERS; k++) begin
        cnt[k] <= cnt_wr[k] ? bus.wdata_i[CNT_W-1:0] : cnt[k] + CNT_W'(1);
        if (cmp_wr[k]) cmp[k] <= bus.wdata_i[CNT_W-1:0];
      end
    end
  // the id is frozen while requesting; ack takes priority over withdrawal
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      req   <= 1'b0;
      id    <= '0;
    end else
      case (state)
        IDLE:
          if (any) begin
            state <= REQ;
            req   <= 1'b1;
            id    <= win;
          end
        REQ:
          if (bus.ack_i) begin
            state <= SERVICE;
            req   <= 1'b0;
          end else if (!(|(elig & id_oh))) begin
            state <= IDLE;
            req   <= 1'b0;
          end
        SERVICE: state <= eoi ? IDLE : SERVICE;
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
  assign bus.rdata_o     = rd;
  assign bus.irq_req_o   = req;
  assign bus.irq_id_o    = id;
  assign bus.timer_int_o = pend[NUM_SRC-1:NUM_IRQ];
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed and random stimulus checked against a behavioural model of int_ctrl.
module tb_int_ctrl;
  localparam int NUM_IRQ = 6, NUM_TIMERS = 2, CNT_W = 32;
  localparam int NUM_SRC = NUM_IRQ + NUM_TIMERS;
  localparam longint unsigned CMAX = (64'd1 << CNT_W) - 1;
`ifdef INTC_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0, checks = 0;
  int_ctrl_if #(.NUM_IRQ(NUM_IRQ), .NUM_TIMERS(NUM_TIMERS)) bus();
  int_ctrl #(.NUM_IRQ(NUM_IRQ), .NUM_TIMERS(NUM_TIMERS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  bit m_pend[NUM_SRC], m_mask[NUM_SRC];
  bit m_mode[NUM_IRQ], m_q[NUM_IRQ], m_p[NUM_IRQ], m_s1[NUM_IRQ], m_s2[NUM_IRQ];
  bit m_ten[NUM_TIMERS];
  bit m_ie;
  longint unsigned m_cnt[NUM_TIMERS], m_cmp[NUM_TIMERS];
  int m_phase, m_id;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    foreach (m_pend[i]) begin m_pend[i] = 0; m_mask[i] = 0; end
    foreach (m_mode[i]) begin m_mode[i] = 0; m_q[i] = 0; m_p[i] = 0; m_s1[i] = 0; m_s2[i] = 0; end
    foreach (m_ten[k]) begin m_ten[k] = 0; m_cnt[k] = 0; m_cmp[k] = 0; end
    m_ie = 0; m_phase = 0; m_id = 0;
  endtask
  function automatic logic [31:0] m_read(int a);
    logic [31:0] r = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (a == 0) r[i] = m_mask[i];
      if (a == 2) r[i] = m_pend[i];
      if (a == 1 && i < NUM_IRQ) r[i] = m_mode[i];
    end
    if (a == 3) begin
      r[0] = m_ie;
      for (int k = 0; k < NUM_TIMERS; k++) r[1+k] = m_ten[k];
    end
    for (int k = 0; k < NUM_TIMERS; k++) begin
      if (a == 8 + 2 * k) r = 32'(m_cnt[k]);
      if (a == 9 + 2 * k) r = 32'(m_cmp[k]);
    end
    return r;
  endfunction
  function automatic logic [31:0] m_tint();
    logic [31:0] r = '0;
    for (int k = 0; k < NUM_TIMERS; k++) r[k] = m_pend[NUM_IRQ+k];
    return r;
  endfunction
  // one clock edge of the specified behaviour, from the inputs held across the edge
  task automatic m_step();
    bit np[NUM_SRC];
    bit elig[NUM_SRC];
    int win = -1, cleared = -1, a = int'(bus.waddr_i);
    bit we = bus.we_i;
    logic [31:0] d = bus.wdata_i;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      elig[i] = m_pend[i] && m_mask[i] && m_ie;
      if (elig[i]) win = i;
    end
    if (m_phase == 1 && bus.ack_i && (m_id >= NUM_IRQ || m_mode[m_id])) cleared = m_id;
    for (int i = 0; i < NUM_IRQ; i++)
      np[i] = m_mode[i] ? ((m_q[i] && !m_p[i]) || (m_pend[i] && !(we && a == 2 && d[i]) && cleared != i))
                        : m_q[i];
    for (int k = 0; k < NUM_TIMERS; k++) begin
      int s = NUM_IRQ + k;
      if (we && a == 9 + 2 * k) np[s] = 0;
      else np[s] = (m_ten[k] && m_cnt[k] == m_cmp[k]) || (m_pend[s] && !(we && a == 2 && d[s]) && cleared != s);
    end
    if (m_phase == 0 && win >= 0) begin m_phase = 1; m_id = win; end
    else if (m_phase == 1 && bus.ack_i) m_phase = 2;
    else if (m_phase == 1 && !elig[m_id]) m_phase = 0;
    else if (m_phase == 2 && we && a == 4) m_phase = 0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      m_p[i] = m_q[i];
      m_q[i] = SYNC ? m_s2[i] : bus.irq_i[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = bus.irq_i[i];
    end
    for (int k = 0; k < NUM_TIMERS; k++) begin
      m_cnt[k] = (we && a == 8 + 2 * k) ? (longint'(d) & CMAX) : ((m_cnt[k] + 1) & CMAX);
      if (we && a == 9 + 2 * k) m_cmp[k] = longint'(d) & CMAX;
    end
    if (we && a == 0) for (int i = 0; i < NUM_SRC; i++) m_mask[i] = d[i];
    if (we && a == 1) for (int i = 0; i < NUM_IRQ; i++) m_mode[i] = d[i];
    if (we && a == 3) begin
      m_ie = d[0];
      for (int k = 0; k < NUM_TIMERS; k++) m_ten[k] = d[1+k];
    end
    m_pend = np;
  endtask
  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    check("req", 32'(bus.irq_req_o), 32'(m_phase == 1));
    check("id", 32'(bus.irq_id_o), 32'(m_id));
    check("tint", 32'(bus.timer_int_o), m_tint());
    check("rdata", bus.rdata_o, m_read(int'(bus.raddr_i)));
  endtask
  task automatic wr(int a, logic [31:0] d);
    bus.we_i = 1'b1;
    bus.waddr_i = 5'(a);
    bus.wdata_i = d;
    tick();
    bus.we_i = 1'b0;
  endtask
  task automatic wait_req(string tag, int lim);
    int n = 0;
    while (!bus.irq_req_o && n < lim) begin tick(); n++; end
    check(tag, 32'(bus.irq_req_o), 32'd1);
  endtask
  task automatic ack_pulse();
    bus.ack_i = 1'b1;
    tick();
    bus.ack_i = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    bit drop, got3;
    bus.irq_i = '0; bus.we_i = 0; bus.waddr_i = '0; bus.wdata_i = '0; bus.raddr_i = '0; bus.ack_i = 0;
    m_reset();
    @(negedge clk);
    for (int a = 0; a < 32; a++) begin
      bus.raddr_i = 5'(a);
      #1 check("rst_rdata", bus.rdata_o, 32'd0);
    end
    check("rst_req", 32'(bus.irq_req_o), 32'd0);
    check("rst_id", 32'(bus.irq_id_o), 32'd0);
    check("rst_tint", 32'(bus.timer_int_o), 32'd0);
    @(negedge clk) rst = 1'b0;
    // edge pulse on line 0: request after E2 (E3 with the synchroniser)
    wr(0, 32'h1); wr(1, 32'h1); wr(3, 32'h1);
    bus.raddr_i = 5'd2;
    bus.irq_i[0] = 1'b1;
    tick();
    bus.irq_i[0] = 1'b0;
    repeat (SYNC + 1) tick();
    check("lat_early", 32'(bus.irq_req_o), 32'd0);
    tick();
    check("lat_req", 32'(bus.irq_req_o), 32'd1);
    check("lat_id", 32'(bus.irq_id_o), 32'd0);
    ack_pulse();
    check("ack_pend", bus.rdata_o, 32'd0);
    check("ack_req", 32'(bus.irq_req_o), 32'd0);
    wr(4, 32'h0);
    repeat (2) tick();
    // level lines 1 and 3: priority, withdrawal, re-request
    wr(1, 32'h0); wr(0, 32'h3F);
    bus.irq_i = 6'b001010;
    wait_req("lvl_req", 8);
    check("lvl_id1", 32'(bus.irq_id_o), 32'd1);
    bus.irq_i[1] = 1'b0;
    drop = 0; got3 = 0; n = 0;
    while (!got3 && n < 10) begin
      tick(); n++;
      if (!bus.irq_req_o) drop = 1;
      if (drop && bus.irq_req_o && bus.irq_id_o == 5'd3) got3 = 1;
    end
    check("lvl_withdraw", 32'(drop), 32'd1);
    check("lvl_id3", 32'(got3), 32'd1);
    ack_pulse();
    bus.irq_i = '0;
    repeat (3) tick();
    wr(4, 32'h0);
    repeat (2) tick();
    // timer 0: compare 20 from count 0
    wr(0, 32'(1) << NUM_IRQ);
    wr(8, 32'd100); wr(9, 32'd20); wr(3, 32'h3); wr(8, 32'd0);
    n = 0;
    while (!bus.timer_int_o[0] && n < 40) begin tick(); n++; end
    check("tmr_lat", 32'(n), 32'd21);
    wait_req("tmr_req", 4);
    check("tmr_id", 32'(bus.irq_id_o), 32'(NUM_IRQ));
    wr(9, 32'd20);
    check("tmr_clr", 32'(bus.timer_int_o[0]), 32'd0);
    repeat (2) tick();
    // wraparound of the count
    wr(3, 32'h1); wr(8, 32'd100); wr(9, 32'd1); wr(3, 32'h3); wr(8, 32'hFFFF_FFFE);
    n = 0;
    while (!bus.timer_int_o[0] && n < 20) begin tick(); n++; end
    check("wrap_lat", 32'(n), 32'd4);
    wr(9, 32'd1); wr(3, 32'h1);
    repeat (3) tick();
    // same-cycle edge set and W1C, then EOI while idle
    wr(0, 32'h0); wr(1, 32'h1);
    bus.raddr_i = 5'd2;
    bus.irq_i[0] = 1'b1;
    tick();
    bus.irq_i[0] = 1'b0;
    wr(2, 32'h1);
    check("w1c_setwins", 32'(bus.rdata_o[0]), 32'd1);
    wr(2, 32'h1);
    check("w1c_clear", 32'(bus.rdata_o[0]), 32'd0);
    wr(4, 32'h0);
    check("eoi_idle", 32'(bus.irq_req_o), 32'd0);
    // asynchronous reset while in service
    wr(0, 32'h4); wr(1, 32'h4); wr(3, 32'h1);
    bus.irq_i[2] = 1'b1;
    tick();
    bus.irq_i[2] = 1'b0;
    wait_req("svc_req", 8);
    check("svc_id", 32'(bus.irq_id_o), 32'd2);
    ack_pulse();
    bus.raddr_i = 5'd0;
    #3 rst = 1'b1;
    #1;
    m_reset();
    check("arst_req", 32'(bus.irq_req_o), 32'd0);
    check("arst_id", 32'(bus.irq_id_o), 32'd0);
    check("arst_tint", 32'(bus.timer_int_o), 32'd0);
    check("arst_mask", bus.rdata_o, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (5) tick();
    check("arst_quiet", 32'(bus.irq_req_o), 32'd0);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      int a;
      logic [31:0] d;
      for (int i = 0; i < NUM_IRQ; i++)
        if ($urandom_range(0, 15) == 0) bus.irq_i[i] = ~bus.irq_i[i];
      bus.raddr_i = 5'($urandom_range(0, 31));
      bus.ack_i = (m_phase == 1) && ($urandom_range(0, 2) == 0);
      bus.we_i = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 10))
        0: a = 0; 1: a = 1; 2: a = 2; 3: a = 3; 4, 5: a = 4;
        6: a = 8; 7: a = 9; 8: a = 10; 9: a = 11;
        default: a = int'($urandom_range(0, 31));
      endcase
      d = $urandom;
      if (a == 3) d[0] = ($urandom_range(0, 3) != 0);
      if (a == 9) d = 32'(m_cnt[0] + longint'($urandom_range(2, 30)));
      if (a == 11) d = 32'(m_cnt[1] + longint'($urandom_range(2, 30)));
      bus.waddr_i = 5'(a);
      bus.wdata_i = d;
      tick();
    end
    bus.we_i = 1'b0;
    bus.ack_i = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
